// File: rtl/seq_mag_comp_if.sv
// Start/done handshake bundle for the sequential magnitude comparator.
// Optional feature macro: SEQ_MAG_COMP_SIGNED_EN (adds signed_mode).
interface seq_mag_comp_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;
    logic [CW-1:0]    digits;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    logic             signed_mode;
`endif

`ifdef SEQ_MAG_COMP_SIGNED_EN
    modport master (
        output start, a, b, signed_mode,
        input  busy, done, lt, gt, eq, digits
    );
    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, lt, gt, eq, digits
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, lt, gt, eq, digits
    );
    modport slave (
        input  start, a, b,
        output busy, done, lt, gt, eq, digits
    );
`endif
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: examines DIGIT bits per clock, MSB first,
// and stops as soon as a digit pair differs or all NDIG digits are equal.
// Optional feature macro: SEQ_MAG_COMP_SIGNED_EN (two's-complement compare
// selected per operation by signed_mode).
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rstn,
    seq_mag_comp_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] NDIG_CNT = CW'(NDIG);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_sa, w_sa_next;
    logic [WIDTH-1:0] r_sb, w_sb_next;
    logic             r_rl, w_rl_next;
    logic             r_rg, w_rg_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_lt, w_lt_next;
    logic             r_gt, w_gt_next;
    logic             r_eq, w_eq_next;
    logic [CW-1:0]    r_digits, w_digits_next;
    logic             r_done, w_done_next;

    logic [DIGIT-1:0] w_da, w_db;
    logic             w_rl_run, w_rg_run;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_exit;
    logic [WIDTH-1:0] w_flip;

    // Current digit pair sits in the top DIGIT bits of the shift registers.
    assign w_da      = r_sa[WIDTH-1 -: DIGIT];
    assign w_db      = r_sb[WIDTH-1 -: DIGIT];
    assign w_rl_run  = r_rl | (w_da < w_db);
    assign w_rg_run  = r_rg | (w_da > w_db);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_exit    = w_rl_run | w_rg_run | (w_cnt_inc == NDIG_CNT);

`ifdef SEQ_MAG_COMP_SIGNED_EN
    // Flipping the sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        w_flip            = '0;
        w_flip[WIDTH-1]   = bus.signed_mode;
    end
`else
    assign w_flip = '0;
`endif

    // Next-state and datapath update for the IDLE/RUN controller.
    always_comb begin
        w_state_next  = r_state;
        w_sa_next     = r_sa;
        w_sb_next     = r_sb;
        w_rl_next     = r_rl;
        w_rg_next     = r_rg;
        w_cnt_next    = r_cnt;
        w_lt_next     = r_lt;
        w_gt_next     = r_gt;
        w_eq_next     = r_eq;
        w_digits_next = r_digits;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_sa_next    = bus.a ^ w_flip;
                    w_sb_next    = bus.b ^ w_flip;
                    w_rl_next    = 1'b0;
                    w_rg_next    = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_sa_next  = r_sa << DIGIT;
                w_sb_next  = r_sb << DIGIT;
                w_rl_next  = w_rl_run;
                w_rg_next  = w_rg_run;
                w_cnt_next = w_cnt_inc;
                if (w_exit) begin
                    // Result registers change only here, so they hold across starts.
                    w_state_next  = S_IDLE;
                    w_lt_next     = w_rl_run;
                    w_gt_next     = w_rg_run;
                    w_eq_next     = ~w_rl_run & ~w_rg_run;
                    w_digits_next = w_cnt_inc;
                    w_done_next   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any compare in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_rl     <= 1'b0;
            r_rg     <= 1'b0;
            r_cnt    <= '0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_digits <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sa     <= w_sa_next;
            r_sb     <= w_sb_next;
            r_rl     <= w_rl_next;
            r_rg     <= w_rg_next;
            r_cnt    <= w_cnt_next;
            r_lt     <= w_lt_next;
            r_gt     <= w_gt_next;
            r_eq     <= w_eq_next;
            r_digits <= w_digits_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = r_done;
    assign bus.lt     = r_lt;
    assign bus.gt     = r_gt;
    assign bus.eq     = r_eq;
    assign bus.digits = r_digits;
endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Multi-cycle, parametrised magnitude comparator. Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock.
- Uses the cascaded less/greater rule: once either flag is set, lower digits cannot change the result.
- Terminates early as soon as the result is decided.
- Sits beside datapath units that need a compare result under a start/done handshake, without a wide single-cycle comparator.

Parameters:
- WIDTH, 16, operand width in bits. Must be ≥1 and a multiple of DIGIT.
- DIGIT, 1, bits compared per cycle. Must be ≥1 and ≤WIDTH.
- NDIG = WIDTH/DIGIT (derived localparam), number of digits.
- CW = clog2(NDIG+1) (derived localparam), counter width.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result registers valid from this cycle
- lt  out  1  A < B of the last completed compare
- gt  out  1  A > B of the last completed compare
- eq  out  1  A == B of the last completed compare
- digits  out  CW  number of digits examined by the last completed compare (1..NDIG)

Behaviour:
- Reset (rstn low, asynchronous, any state including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, lt=0, gt=0, eq=0, digits=0.
  - Internal shift registers, counter and running flags cleared.
  - An in-flight compare is discarded with no done.
- States are IDLE and RUN only.
- IDLE:
  - start=1 at a posedge: load sa←a, sb←b, running flags rl=0, rg=0, cnt=0; go to RUN.
  - busy=1 from the following cycle.
  - start=0: stay in IDLE.
- RUN, each posedge:
  - da = top DIGIT bits of sa; db = top DIGIT bits of sb (unsigned).
  - rl' = rl | (da<db); rg' = rg | (da>db). At most one of rl/rg is ever set: once set, RUN exits that same edge.
  - sa, sb shift left by DIGIT; cnt' = cnt+1.
  - Exit to IDLE if rl' or rg' is set, or cnt' == NDIG. Otherwise stay in RUN.
- On the exit edge:
  - lt←rl', gt←rg', eq←~rl'&~rg', digits←cnt'.
  - done←1, busy←0.
  - done drops at the next edge.
- Result outputs (lt/gt/eq/digits) hold their value until the next completed compare. They are not cleared by start.
- Exactly one of lt/gt/eq is high after the first completed compare.
- Latency: start sampled at edge k; done high after edge k+m for one cycle, with m = digits (1..NDIG). Worst case is NDIG+1 edges from start to done.
- Back-to-back: start high during the done cycle is accepted, because state is already IDLE. No dead cycle.
- start during RUN is ignored. a/b changes during RUN have no effect (operands are captured).
- Operand digits are unsigned unless the optional feature below is enabled and selected.

Optional Feature:
- Macro: SEQ_MAG_COMP_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start.
  - When signed_mode=1, bit WIDTH-1 of both captured operands is inverted at load. This converts two's-complement ordering to unsigned ordering; the rest of the behaviour is unchanged.
  - signed_mode=0 gives unsigned behaviour.
- Not defined:
  - Port signed_mode is absent.
  - All compares are unsigned.

Test Plan:
- Reset: hold rstn=0 with start=1 -> busy=done=lt=gt=eq=0, digits=0. Release rstn, start=0 -> remains IDLE.
- WIDTH=8, DIGIT=1, a=8'h80, b=8'h7F, start at edge k -> done after edge k+1, gt=1, lt=0, eq=0, digits=1.
- WIDTH=8, DIGIT=1, a=b=8'hA5 -> busy for 8 cycles, done after edge k+8, eq=1, digits=8. Then a=8'h12, b=8'h13 started in the done cycle -> accepted, lt=1, digits=8.
- WIDTH=16, DIGIT=4, a=16'h1234, b=16'h1244 -> lt=1, digits=3, done after edge k+3. Changing a during RUN does not alter the result.
- Drive rstn low 2 cycles after start on an equal-operand compare -> no done pulse, all outputs 0. Next compare a=3, b=3 (WIDTH=8, DIGIT=1) completes normally with eq=1.
- With SEQ_MAG_COMP_SIGNED_EN, WIDTH=8, DIGIT=1:
  - signed_mode=1, a=8'h80, b=8'h01 -> lt=1, digits=1.
  - Same operands with signed_mode=0 -> gt=1.
